keypad_scanner: RTL and testbench



---
 rtl/keypad_scanner.sv | 161 ++++++++++++++++
 tb/tb_keypad_scanner.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: drives active-low columns, synchronises and debounces
// the rows, and emits a registered hex key code with a one-cycle valid strobe.
module keypad_scanner #(
    parameter int SCAN_DIV     = 16,
    parameter int DEBOUNCE_CNT = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [3:0] row_in,
    output logic [3:0] col_out,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_held,
    output logic       multi_err
);
    localparam int DW = $clog2(SCAN_DIV);
    localparam int CW = $clog2(DEBOUNCE_CNT + 1);
    localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] CNT_DONE   = CW'(DEBOUNCE_CNT);

    typedef enum logic [1:0] {SCAN, DEBOUNCE, PRESSED, RELEASE} state_t;

    state_t          state, state_n;
    logic [3:0]      sync1, sync2;
    logic [DW-1:0]   dwell, dwell_n;
    logic [CW-1:0]   cnt, cnt_n;
    logic [1:0]      col, col_n;
    logic [1:0]      row_q, row_n;
    logic [3:0]      code_n;
    logic            valid_n, held_n, merr_n;
    logic            tick, s_none, s_single, s_multi;
    logic [1:0]      s_row;

    function automatic logic [3:0] key_map(input logic [1:0] r, input logic [1:0] c);
        case ({r, c})
            4'h0: key_map = 4'h1;  4'h1: key_map = 4'h2;  4'h2: key_map = 4'h3;  4'h3: key_map = 4'hA;
            4'h4: key_map = 4'h4;  4'h5: key_map = 4'h5;  4'h6: key_map = 4'h6;  4'h7: key_map = 4'hB;
            4'h8: key_map = 4'h7;  4'h9: key_map = 4'h8;  4'hA: key_map = 4'h9;  4'hB: key_map = 4'hC;
            4'hC: key_map = 4'hE;  4'hD: key_map = 4'h0;  4'hE: key_map = 4'hF;  default: key_map = 4'hD;
        endcase
    endfunction

    assign col_out = ~(4'b0001 << col);

    // Sample classification; a multi-row sample behaves as "no key"
    assign tick     = (dwell == DWELL_LAST);
    assign s_single = $onehot(~sync2);
    assign s_multi  = (sync2 != 4'hF) && !s_single;
    assign s_none   = !s_single;
    always_comb begin
        case (sync2)
            4'b1110: s_row = 2'd0;
            4'b1101: s_row = 2'd1;
            4'b1011: s_row = 2'd2;
            default: s_row = 2'd3;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1     <= 4'hF;
            sync2     <= 4'hF;
            state     <= SCAN;
            dwell     <= '0;
            cnt       <= '0;
            col       <= 2'd0;
            row_q     <= 2'd0;
            key_code  <= 4'h0;
            key_valid <= 1'b0;
            key_held  <= 1'b0;
            multi_err <= 1'b0;
        end else begin
            sync1     <= row_in;
            sync2     <= sync1;
            state     <= state_n;
            dwell     <= dwell_n;
            cnt       <= cnt_n;
            col       <= col_n;
            row_q     <= row_n;
            key_code  <= code_n;
            key_valid <= valid_n;
            key_held  <= held_n;
            multi_err <= merr_n;
        end
    end

    always_comb begin
        state_n = state;
        dwell_n = dwell;
        cnt_n   = cnt;
        col_n   = col;
        row_n   = row_q;
        code_n  = key_code;
        valid_n = 1'b0;
        held_n  = key_held;
        merr_n  = multi_err;
        if (ena) begin
            dwell_n = tick ? '0 : dwell + DW'(1);
            if (tick) begin
                if (s_multi) merr_n = 1'b1;
                case (state)
                    SCAN: begin
                        if (s_single) begin
                            row_n = s_row;
                            if (DEBOUNCE_CNT == 1) begin
                                state_n = PRESSED;
                                code_n  = key_map(s_row, col);
                                valid_n = 1'b1;
                                held_n  = 1'b1;
                            end else begin
                                state_n = DEBOUNCE;
                                cnt_n   = CW'(1);
                            end
                        end else begin
                            col_n = col + 2'd1;
                        end
                    end
                    DEBOUNCE: begin
                        if (s_single && s_row == row_q) begin
                            cnt_n = cnt + CW'(1);
                            if (cnt + CW'(1) == CNT_DONE) begin
                                state_n = PRESSED;
                                code_n  = key_map(row_q, col);
                                valid_n = 1'b1;
                                held_n  = 1'b1;
                            end
                        end else begin
                            state_n = SCAN;
                            col_n   = col + 2'd1;
                        end
                    end
                    PRESSED: begin
                        if (s_none) begin
                            if (DEBOUNCE_CNT == 1) begin
                                state_n = SCAN;
                                held_n  = 1'b0;
                                col_n   = col + 2'd1;
                            end else begin
                                state_n = RELEASE;
                                cnt_n   = CW'(1);
                            end
                        end
                    end
                    default: begin // RELEASE
                        if (s_none) begin
                            cnt_n = cnt + CW'(1);
                            if (cnt + CW'(1) == CNT_DONE) begin
                                state_n = SCAN;
                                held_n  = 1'b0;
                                col_n   = col + 2'd1;
                            end
                        end else begin
                            state_n = PRESSED;
                        end
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with a behavioural 4x4 keypad model.
module tb_keypad_scanner;
    logic       clk = 1'b0;
    logic       rst_n, ena;
    logic [3:0] row_in, col_out, key_code;
    logic       key_valid, key_held, multi_err;
    logic [3:0] key_dn [4];   // key_dn[r][c] = key at row r, column c is pressed
    int         checks = 0, errors = 0;
    int         pulse_cnt = 0;

    typedef struct {
        logic       ena_next;
        logic [3:0] col;
    } vec_t;
    vec_t vecs [28];

    keypad_scanner #(.SCAN_DIV(4), .DEBOUNCE_CNT(3)) dut (
        .clk(clk), .rst_n(rst_n), .ena(ena), .row_in(row_in), .col_out(col_out),
        .key_code(key_code), .key_valid(key_valid), .key_held(key_held), .multi_err(multi_err)
    );

    always #5 clk = ~clk;

    always_comb begin
        row_in = 4'hF;
        for (int r = 0; r < 4; r++) row_in[r] = ~|(key_dn[r] & ~col_out);
    end

    always @(negedge clk) if (key_valid === 1'b1) pulse_cnt <= pulse_cnt + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    task automatic wait_valid(input int maxc);
        int n = 0;
        while (key_valid !== 1'b1 && n < maxc) begin @(negedge clk); n++; end
    endtask

    task automatic wait_held_low(input int maxc, output int n);
        n = 0;
        while (key_held !== 1'b0 && n < maxc) begin @(negedge clk); n++; end
    endtask

    initial begin
        logic [3:0] cols [4];
        logic [3:0] prev;
        int p0, n, chg, run;
        cols = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
        for (int i = 0; i < 20; i++) vecs[i] = '{1'b1, cols[(i / 4) % 4]};
        vecs[20] = '{1'b0, 4'b1101};
        vecs[21] = '{1'b0, 4'b1101};
        vecs[22] = '{1'b0, 4'b1101};
        vecs[23] = '{1'b1, 4'b1101};
        vecs[24] = '{1'b1, 4'b1101};
        vecs[25] = '{1'b1, 4'b1101};
        vecs[26] = '{1'b1, 4'b1101};
        vecs[27] = '{1'b1, 4'b1011};
        for (int r = 0; r < 4; r++) key_dn[r] = 4'h0;
        rst_n = 1'b0;
        ena   = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_col", col_out, 4'b1110);
        chk("rst_code", key_code, 4'h0);
        chk("rst_valid", key_valid, 1'b0);
        chk("rst_held", key_held, 1'b0);
        chk("rst_merr", multi_err, 1'b0);
        #2 rst_n = 1'b1;

        // Idle scan sequence, including an ena=0 freeze
        for (int i = 0; i < 28; i++) begin
            chk($sformatf("scan_col[%0d]", i), col_out, vecs[i].col);
            chk($sformatf("scan_valid[%0d]", i), key_valid, 1'b0);
            chk($sformatf("scan_merr[%0d]", i), multi_err, 1'b0);
            ena = vecs[i].ena_next;
            @(negedge clk);
        end

        // Key 6 (row1, column2): single pulse, no auto-repeat
        key_dn[1] = 4'b0100;
        wait_valid(60);
        chk("k6_valid", key_valid, 1'b1);
        chk("k6_code", key_code, 4'h6);
        chk("k6_held", key_held, 1'b1);
        chk("k6_col", col_out, 4'b1011);
        @(negedge clk);
        chk("k6_valid_1cyc", key_valid, 1'b0);
        p0 = pulse_cnt;
        repeat (200) @(negedge clk);
        chk("k6_no_repeat", pulse_cnt - p0, 0);
        chk("k6_col_frozen", col_out, 4'b1011);
        chk("k6_held_hold", key_held, 1'b1);

        // Release key 6
        key_dn[1] = 4'h0;
        wait_held_low(30, n);
        chk("k6_rel_held", key_held, 1'b0);
        chk("k6_rel_latency_ok", (n >= 11 && n <= 14), 1'b1);
        chk("k6_rel_col", col_out, 4'b0111);
        chk("k6_rel_code", key_code, 4'h6);

        // Two rows low on column 1: sticky error, no key, scanning continues
        key_dn[0] = 4'b0010;
        key_dn[2] = 4'b0010;
        p0 = pulse_cnt;
        prev = col_out;
        chg = 0;
        repeat (40) begin
            @(negedge clk);
            if (col_out != prev) chg++;
            prev = col_out;
        end
        chk("multi_err_set", multi_err, 1'b1);
        chk("multi_no_valid", pulse_cnt - p0, 0);
        chk("multi_scanning", chg >= 8, 1'b1);
        key_dn[0] = 4'h0;
        key_dn[2] = 4'h0;
        repeat (8) @(negedge clk);
        chk("multi_sticky", multi_err, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("multi_rst_clear", multi_err, 1'b0);
        chk("multi_rst_col", col_out, 4'b1110);
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;

        // Bouncing E (row3, column0) then steady hold
        p0 = pulse_cnt;
        for (int k = 0; k < 6; k++) begin
            key_dn[3] = (k % 2 == 0) ? 4'b0001 : 4'b0000;
            repeat (5) @(negedge clk);
        end
        key_dn[3] = 4'b0001;
        wait_valid(60);
        chk("kE_valid", key_valid, 1'b1);
        chk("kE_code", key_code, 4'hE);
        chk("kE_col", col_out, 4'b1110);
        @(negedge clk);
        chk("kE_one_pulse", pulse_cnt - p0, 1);
        key_dn[3] = 4'h0;
        wait_held_low(40, n);
        chk("kE_released", key_held, 1'b0);

        // Key D (row3, column3): reset while debouncing
        key_dn[3] = 4'b1000;
        run = 0;
        n = 0;
        while (run < 6 && n < 100) begin
            @(negedge clk);
            n++;
            run = (col_out == 4'b0111) ? run + 1 : 0;
        end
        chk("kD_in_debounce", run, 6);
        #2 rst_n = 1'b0;
        #1;
        chk("kD_rst_col", col_out, 4'b1110);
        chk("kD_rst_code", key_code, 4'h0);
        chk("kD_rst_valid", key_valid, 1'b0);
        chk("kD_rst_held", key_held, 1'b0);
        chk("kD_rst_merr", multi_err, 1'b0);
        p0 = pulse_cnt;
        repeat (3) @(negedge clk);
        chk("kD_in_rst_no_valid", pulse_cnt - p0, 0);
        #2 rst_n = 1'b1;
        p0 = pulse_cnt;
        repeat (23) @(negedge clk);
        chk("kD_no_early_valid", pulse_cnt - p0, 0);
        @(negedge clk);
        chk("kD_valid", key_valid, 1'b1);
        chk("kD_code", key_code, 4'hD);
        chk("kD_held", key_held, 1'b1);
        chk("kD_col", col_out, 4'b0111);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
